// File: rtl/idu_seq.sv
// idu_seq: sequential front end of the T84C increment/decrement unit.
// Holds the IDU register, forms pass/inc/dec results through a grouped
// carry-lookahead chain, and returns them over a done/ack handshake.
// A repeat-decrement mode counts the register down once per clock until it
// reaches zero (or abort is raised), for BC counting in block instructions.
// Optional feature: define IDU_ZERO_DETECT_EN to register a zero flag
// alongside dout; otherwise zero is tied low.
//
// state | meaning
// IDLE  | waiting for start; captures din/op
// CALC  | single-cycle pass/inc/dec, writes dout
// RPT   | decrement once per clock until zero or abort
// HOLD  | done high, result held until ack
module idu_seq #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] din,
    input  logic             abort,
    input  logic             ack,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [WIDTH-1:0] dout,
    output logic             carry_out,
    output logic             zero
);

    localparam int NGRP = WIDTH / GROUP;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_RPT  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, RPT, HOLD} state_t;

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [1:0]       op_l;

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] cy;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dec_val;
    logic [WIDTH-1:0] res;
    logic             c_all;
    logic             gc;
    logic             run;

    logic             wb_en;
    logic [WIDTH-1:0] wb_val;
    logic             wb_carry;

    // Increment works on q directly; decrement reuses the same chain on ~q.
    assign a_in = (op_l == OP_INC) ? q : ~q;

    // Grouped lookahead: group carry-in is the AND of all lower groups, then
    // ripples inside the group. cy[i] ends up as AND(a_in[i-1:0]).
    always_comb begin
        cy  = '0;
        gc  = 1'b1;
        run = 1'b1;
        for (int g = 0; g < NGRP; g++) begin
            run = gc;
            for (int k = 0; k < GROUP; k++) begin
                cy[g*GROUP+k] = run;
                run           = run & a_in[g*GROUP+k];
            end
            gc = gc & (&a_in[g*GROUP +: GROUP]);
        end
        c_all = gc;
    end

    assign sum     = a_in ^ cy;
    assign dec_val = ~sum;

    // Result select for the single-cycle CALC operation.
    always_comb begin
        case (op_l)
            OP_PASS: res = q;
            OP_INC:  res = sum;
            default: res = dec_val;
        endcase
    end

    // Writeback decision: CALC always writes; RPT writes on abort or when
    // the count lands on zero. The 0 -> all-ones wrap is not a terminal case.
    always_comb begin
        wb_en    = 1'b0;
        wb_val   = res;
        wb_carry = 1'b0;
        case (state)
            CALC: begin
                wb_en    = 1'b1;
                wb_val   = res;
                wb_carry = ((op_l == OP_INC) || (op_l == OP_DEC)) && c_all;
            end
            RPT: begin
                if (abort) begin
                    wb_en  = 1'b1;
                    wb_val = q;
                end else if (dec_val == '0) begin
                    wb_en  = 1'b1;
                    wb_val = '0;
                end
            end
            default: ;
        endcase
    end

    // Sequencer state, IDU register and registered handshake outputs.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            q         <= '0;
            op_l      <= OP_PASS;
            dout      <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            step      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            step <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        q     <= din;
                        op_l  <= op;
                        busy  <= 1'b1;
                        state <= (op == OP_RPT) ? RPT : CALC;
                    end
                end
                CALC: begin
                    dout      <= wb_val;
                    carry_out <= wb_carry;
                    done      <= 1'b1;
                    state     <= HOLD;
                end
                RPT: begin
                    if (!abort) begin
                        q    <= dec_val;
                        step <= 1'b1;
                    end
                    if (wb_en) begin
                        dout      <= wb_val;
                        carry_out <= 1'b0;
                        done      <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (ack) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IDU_ZERO_DETECT_EN
    // Zero flag tracks whatever is written into dout.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            zero <= 1'b0;
        end else if (wb_en) begin
            zero <= ~|wb_val;
        end
    end
`else
    assign zero = 1'b0;
`endif

endmodule
